// File: rtl/flex_counter_strobe.sv
// flex_counter_strobe: tick-qualified up counter with programmable terminal
// value, periodic or one-shot mode, halt control and a registered terminal
// flag. Optional build macro FLEX_CNT_ROLL_COUNT_EN adds a wrap/DONE event
// counter output (rollover_count).
module flex_counter_strobe #(
  parameter int unsigned NUM_CNT_BITS  = 4,
  parameter int unsigned ROLL_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clk12,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     halt,
  input  logic                     one_shot,
  input  logic [NUM_CNT_BITS-1:0]  rollover_value,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     busy,
  output logic                     done
`ifdef FLEX_CNT_ROLL_COUNT_EN
  ,
  output logic [ROLL_CNT_BITS-1:0] rollover_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Reject degenerate widths at elaboration time.
  if (NUM_CNT_BITS < 1 || ROLL_CNT_BITS < 1) begin : g_param_check
    $error("flex_counter_strobe: NUM_CNT_BITS and ROLL_CNT_BITS must be >= 1");
  end

  state_e                  state_q;
  state_e                  state_d;
  logic [NUM_CNT_BITS-1:0] count_d;
  logic [NUM_CNT_BITS-1:0] adv_count;
  logic                    adv_term;
  logic                    flag_d;
  logic                    rv_nonzero;

  assign rv_nonzero = (rollover_value != '0);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, next-count and next-flag decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_out;
    adv_count = NUM_CNT_BITS'(1);
    adv_term  = 1'b0;
    flag_d    = 1'b0;

    // Count an enabled active tick would produce; 0 is skipped on wrap and
    // a count left above a lowered terminal value restarts at 1.
    if (count_out < rollover_value) begin
      adv_count = NUM_CNT_BITS'(count_out + 1'b1);
    end else if ((count_out == rollover_value) && one_shot) begin
      adv_count = count_out;
    end else begin
      adv_count = NUM_CNT_BITS'(1);
    end
    adv_term = one_shot && (adv_count == rollover_value);

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (clk12) begin
      unique case (state_q)
        IDLE: begin
          if (count_enable && !halt && rv_nonzero) begin
            count_d = NUM_CNT_BITS'(1);
            state_d = (one_shot && (rollover_value == NUM_CNT_BITS'(1))) ? DONE : RUN;
          end
        end
        RUN, HALTED: begin
          if (halt) begin
            state_d = HALTED;
          end else if (!rv_nonzero) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
            if (count_enable) begin
              count_d = adv_count;
              if (adv_term) begin
                state_d = DONE;
              end
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // DONE freezes the flag; elsewhere it tracks the next count.
    if (clear) begin
      flag_d = 1'b0;
    end else if (state_q == DONE) begin
      flag_d = rollover_flag;
    end else begin
      flag_d = rv_nonzero && (count_d == rollover_value);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      count_out     <= count_d;
      rollover_flag <= flag_d;
      busy          <= (state_d == RUN) || (state_d == HALTED);
      done          <= (state_d == DONE);
    end
  end

`ifdef FLEX_CNT_ROLL_COUNT_EN
  logic wrap_event;
  logic done_entry;
  logic roll_inc;

  // A periodic wrap is an enabled active tick taken at the terminal value.
  assign wrap_event = !clear && clk12 && !halt && count_enable && rv_nonzero &&
                      !one_shot && (count_out == rollover_value) &&
                      ((state_q == RUN) || (state_q == HALTED));
  assign done_entry = (state_d == DONE) && (state_q != DONE);
  assign roll_inc   = wrap_event || done_entry;

  // Rollover event counter, wraps modulo 2^ROLL_CNT_BITS.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rollover_count <= '0;
    end else if (clear) begin
      rollover_count <= '0;
    end else if (roll_inc) begin
      rollover_count <= ROLL_CNT_BITS'(rollover_count + 1'b1);
    end
  end
`endif

endmodule

// File: doc/flex_counter_strobe.md
FLEX_COUNTER_STROBE -- requirements
Module: flex_counter_strobe

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, width of count and rollover value.
REQ-002 SHALL have parameter ROLL_CNT_BITS, default 8, width of rollover event counter (used only under REQ-032).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clk12  input  1  tick qualifier, single-cycle strobe in clk domain; counting evaluated only when high.
REQ-006 SHALL have port clear  input  1  synchronous restart to IDLE, not qualified by clk12.
REQ-007 SHALL have port count_enable  input  1  advance count on qualified tick.
REQ-008 SHALL have port halt  input  1  freeze count on qualified tick.
REQ-009 SHALL have port one_shot  input  1  1 = stop at terminal value, 0 = periodic wrap.
REQ-010 SHALL have port rollover_value  input  NUM_CNT_BITS  terminal count.
REQ-011 SHALL have port count_out  output  NUM_CNT_BITS  registered current count.
REQ-012 SHALL have port rollover_flag  output  1  registered, high iff count_out == rollover_value and rollover_value != 0.
REQ-013 SHALL have port busy  output  1  high in RUN or HALTED.
REQ-014 SHALL have port done  output  1  high in DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HALTED, DONE; "tick" = rising clk with clk12=1.
REQ-016 Priority SHALL be clear > halt > count_enable; clear acts on any clk edge.
REQ-017 clear SHALL force next state IDLE, count_out=0, rollover_flag=0, regardless of state or clk12.
REQ-018 IDLE->RUN on tick with count_enable=1, halt=0, rollover_value!=0; count_out becomes 1 on that same tick.
REQ-019 RUN, tick, halt=1 -> HALTED; count_out and rollover_flag hold.
REQ-020 HALTED, tick, halt=0 -> RUN; count resumes on the same tick if count_enable=1.
REQ-021 RUN, tick, count_enable=1, count_out < rollover_value: count_out+1.
REQ-022 RUN, tick, count_enable=1, count_out == rollover_value, one_shot=0: count_out=1 (wrap, 0 skipped).
REQ-023 RUN, tick, count_out+1 == rollover_value, one_shot=1: count_out=rollover_value, next state DONE.
REQ-024 DONE SHALL hold count_out and flag until clear; count_enable, halt, one_shot ignored.
REQ-025 count_out > rollover_value on enabled RUN tick (value lowered mid-run): count_out=1, no flag.
REQ-026 rollover_value == 0: SHALL remain in/return to IDLE semantics-wise with count_out held, flag 0, no DONE.
REQ-027 count_enable=0 or no tick: count_out holds; flag recomputed from held count and current rollover_value.
REQ-028 Latency: rollover_flag SHALL assert in the same cycle count_out first equals rollover_value (both registered).
REQ-029 Arithmetic SHALL be unsigned NUM_CNT_BITS; rollover_value = 2^N-1 SHALL reach full scale without overflow.

Reset
REQ-030 n_rst low SHALL asynchronously set state IDLE, count_out=0, rollover_flag=0, busy=0, done=0 (and rollover_count=0 if present).
REQ-031 Reset deassertion mid-operation SHALL restart from IDLE; no partial state retained.

Configuration
REQ-032 Macro FLEX_CNT_ROLL_COUNT_EN defined: SHALL add output rollover_count (ROLL_CNT_BITS), incremented on every periodic wrap (REQ-022) and on DONE entry, wrapping modulo 2^ROLL_CNT_BITS, cleared by clear and reset.
REQ-033 Macro undefined: rollover_count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 N=4, rollover_value=5, one_shot=0, clk12 every 4th cycle, count_enable=1 -> count 1,2,3,4,5,1,2; flag high only while count=5.
REQ-035 rollover_value=3, one_shot=1 -> count 1,2,3 then hold 3; done=1, busy=0, flag=1 until clear; clear -> count 0, IDLE.
REQ-036 At count=2, halt=1 for 3 ticks -> count stays 2, busy=1; halt=0 -> next tick count 3.
REQ-037 At count=7 with rollover_value=9, change rollover_value to 4 -> next enabled tick count=1, flag 0; clear and halt asserted together with clk12=0 -> count 0 next edge.
REQ-038 rollover_value=15, N=4 -> reaches 15, flag=1, wraps to 1; n_rst pulsed mid-count -> all outputs 0 immediately, asynchronous to clk.
REQ-039 With FLEX_CNT_ROLL_COUNT_EN, rollover_value=2, periodic, 300 wraps -> rollover_count=44 (300 mod 256); without macro, port absent and REQ-034 passes unchanged.
